// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone memory responder: transfer width
// encodings, FSM states, and byte-lane helper functions.
package wb_pkg;

    localparam logic [1:0] WB_BYTE  = 2'b00;
    localparam logic [1:0] WB_SHORT = 2'b01;
    localparam logic [1:0] WB_WORD  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_t;

    // Little-endian byte enables; width 2'b11 is handled like a word.
    function automatic logic [3:0] wb_byte_en(input logic [1:0] width,
                                              input logic [1:0] addr_lo);
        case (width)
            WB_BYTE:  wb_byte_en = 4'b0001 << addr_lo;
            WB_SHORT: wb_byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:  wb_byte_en = 4'b1111;
        endcase
    endfunction

    // True when the low address bits do not match the natural alignment.
    function automatic logic wb_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
        case (width)
            WB_BYTE:  wb_misaligned = 1'b0;
            WB_SHORT: wb_misaligned = addr_lo[0];
            default:  wb_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/wb_byte_lane.sv
// Combinational byte-lane steering: positions right-aligned write data onto
// its lanes with matching enables, and right-aligns/zero-extends read data.
module wb_byte_lane
    import wb_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_lanes,
    output logic [31:0] rd_data
);

    // Replicate write data across lanes; the byte enables pick the live ones.
    always_comb begin
        byte_en = wb_byte_en(width, addr_lo);
        case (width)
            WB_BYTE:  wr_lanes = {4{wr_data[7:0]}};
            WB_SHORT: wr_lanes = {2{wr_data[15:0]}};
            default:  wr_lanes = wr_data;
        endcase
    end

    // Shift the selected lanes down and zero-extend.
    always_comb begin
        rd_data = '0;
        case (width)
            WB_BYTE: begin
                case (addr_lo)
                    2'd0:    rd_data[7:0] = rd_word[7:0];
                    2'd1:    rd_data[7:0] = rd_word[15:8];
                    2'd2:    rd_data[7:0] = rd_word[23:16];
                    default: rd_data[7:0] = rd_word[31:24];
                endcase
            end
            WB_SHORT: rd_data[15:0] = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
            default:  rd_data = rd_word;
        endcase
    end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone single-beat slave RAM with configurable response latency.
// Optional macro WB_MEM_RESPONDER_ALIGN_ERR_EN adds o_wb_err, which completes
// misaligned requests with an error pulse instead of an ack.
module wb_mem_responder
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [1:0]  i_data_width,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
    ,
    output logic        o_wb_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    wb_state_t             state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic                  go_ack;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic                  we_q;
    logic [31:0]           data_q;
    logic [1:0]            width_q;
    logic                  err_q;

    logic [ADDR_WIDTH+1:0] cur_addr;
    logic                  cur_we;
    logic [31:0]           cur_data;
    logic [1:0]            cur_width;
    logic                  bad;
    logic [3:0]            byte_en;
    logic [31:0]           wr_lanes;
    logic [31:0]           rd_word;
    logic [31:0]           rd_data;
    logic                  req;
    logic                  unused_addr;

    logic [31:0] mem [DEPTH];

    assign req         = i_wb_cyc && i_wb_stb;
    assign unused_addr = &{1'b0, i_wb_addr[31:ADDR_WIDTH+2]};

    // With zero wait states the transfer completes from IDLE, so the live bus
    // fields stand in for the latched ones on that edge.
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = i_wb_addr[ADDR_WIDTH+1:0];
            cur_we    = i_wb_we;
            cur_data  = i_wb_data;
            cur_width = i_data_width;
        end else begin
            cur_addr  = addr_q;
            cur_we    = we_q;
            cur_data  = data_q;
            cur_width = width_q;
        end
    end

    // Misalignment only matters when the error response is built in.
    always_comb begin
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
        bad = wb_misaligned(cur_width, cur_addr[1:0]);
`else
        bad = 1'b0;
`endif
    end

    assign rd_word = mem[cur_addr[ADDR_WIDTH+1:2]];

    wb_byte_lane u_lane (
        .width    (cur_width),
        .addr_lo  (cur_addr[1:0]),
        .wr_data  (cur_data),
        .rd_word  (rd_word),
        .byte_en  (byte_en),
        .wr_lanes (wr_lanes),
        .rd_data  (rd_data)
    );

    // Next-state and wait-counter logic; go_ack marks the edge entering ACK.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        go_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nx = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_nx = ACK;
                        go_ack   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt <= 4'd1) begin
                    state_nx = ACK;
                    go_ack   = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, request latches, read-data register and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            data_q    <= '0;
            width_q   <= '0;
            err_q     <= 1'b0;
            o_wb_data <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req) begin
                addr_q  <= i_wb_addr[ADDR_WIDTH+1:0];
                we_q    <= i_wb_we;
                data_q  <= i_wb_data;
                width_q <= i_data_width;
            end
            if (go_ack) begin
                err_q <= bad;
                if (!cur_we && !bad)
                    o_wb_data <= rd_data;
            end
        end
    end

    // Memory array is never reset; masked write commits on the edge entering ACK.
    always_ff @(posedge clk) begin
        if (go_ack && cur_we && !bad) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[cur_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    assign o_wb_ack = (state == ACK) && !err_q;
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
    assign o_wb_err = (state == ACK) && err_q;
`endif

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: one instance with one wait state,
// one with three; read expectations go through a scoreboard queue.
module tb_wb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  width [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
    logic        err   [2];
`endif

    logic [31:0] rd_q [$];
    logic [31:0] last_rd [2];
    int checks = 0;
    int errors = 0;

    wb_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset),
        .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
        .i_wb_addr(addr[0]), .i_wb_data(wdata[0]), .i_data_width(width[0]),
        .o_wb_data(rdata[0]), .o_wb_ack(ack[0])
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
        , .o_wb_err(err[0])
`endif
    );

    wb_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset),
        .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
        .i_wb_addr(addr[1]), .i_wb_data(wdata[1]), .i_data_width(width[1]),
        .o_wb_data(rdata[1]), .o_wb_ack(ack[1])
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
        , .o_wb_err(err[1])
`endif
    );

    function automatic int ws_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    task automatic drive_req(input int s, input logic w_en, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] w);
        @(negedge clk);
        cyc[s] = 1'b1; stb[s] = 1'b1; we[s] = w_en;
        addr[s] = a; wdata[s] = d; width[s] = w;
        @(posedge clk);
        #1 stb[s] = 1'b0;
    endtask

    // Full transfer: checks ack latency, single-cycle ack, and read data or
    // read-data hold on writes.
    task automatic xfer(input int s, input logic w_en, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] w);
        int lat;
        logic [31:0] exp;
        drive_req(s, w_en, a, d, w);
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (ack[s] === 1'b1) lat = n;
        end
        checks++;
        if (lat != ws_of(s) + 1) begin
            errors++;
            $display("FAIL ack_latency inst%0d addr %h: got %0d cycles expected %0d", s, a, lat, ws_of(s) + 1);
        end
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
        checks++;
        if (err[s] !== 1'b0) begin
            errors++;
            $display("FAIL err_on_good inst%0d addr %h: got %b expected 0", s, a, err[s]);
        end
`endif
        if (!w_en) begin
            exp = rd_q.pop_front();
            checks++;
            if (rdata[s] !== exp) begin
                errors++;
                $display("FAIL read_data inst%0d addr %h: got %h expected %h", s, a, rdata[s], exp);
            end
            last_rd[s] = exp;
        end else begin
            checks++;
            if (rdata[s] !== last_rd[s]) begin
                errors++;
                $display("FAIL data_hold_on_write inst%0d: got %h expected %h", s, rdata[s], last_rd[s]);
            end
        end
        @(negedge clk);
        checks++;
        if (ack[s] !== 1'b0) begin
            errors++;
            $display("FAIL ack_width inst%0d: got %b expected 0", s, ack[s]);
        end
        cyc[s] = 1'b0;
    endtask

    task automatic wr(input int s, input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        xfer(s, 1'b1, a, d, w);
    endtask

    task automatic rd(input int s, input logic [31:0] a, input logic [1:0] w, input logic [31:0] exp);
        rd_q.push_back(exp);
        xfer(s, 1'b0, a, 32'h0, w);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ack[s] !== 1'b0 || rdata[s] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got ack %b data %h expected ack 0 data 0", s, ack[s], rdata[s]);
            end
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
            checks++;
            if (err[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_err inst%0d: got %b expected 0", s, err[s]);
            end
`endif
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word();
        wr(0, 32'h10, 32'hDEADBEEF, 2'b10);
        rd(0, 32'h10, 2'b10, 32'hDEADBEEF);
    endtask

    task automatic test_bytes();
        wr(0, 32'h20, 32'h11, 2'b00);
        wr(0, 32'h21, 32'h22, 2'b00);
        wr(0, 32'h22, 32'h33, 2'b00);
        wr(0, 32'h23, 32'h44, 2'b00);
        rd(0, 32'h20, 2'b10, 32'h44332211);
        rd(0, 32'h22, 2'b00, 32'h00000033);
        rd(0, 32'h23, 2'b00, 32'h00000044);
    endtask

    task automatic test_short();
        wr(0, 32'h30, 32'hFFFFFFFF, 2'b10);
        wr(0, 32'h32, 32'hABCD, 2'b01);
        rd(0, 32'h30, 2'b10, 32'hABCDFFFF);
        rd(0, 32'h32, 2'b01, 32'h0000ABCD);
        rd(0, 32'h30, 2'b11, 32'hABCDFFFF);
    endtask

    task automatic test_wrap();
        wr(0, 32'h1000, 32'hCAFEF00D, 2'b10);
        rd(0, 32'h0000, 2'b10, 32'hCAFEF00D);
    endtask

    task automatic test_abort();
        int acks;
        wr(1, 32'h40, 32'h55AA55AA, 2'b10);
        rd(1, 32'h40, 2'b10, 32'h55AA55AA);
        drive_req(1, 1'b1, 32'h40, 32'h12345678, 2'b10);
        @(negedge clk);
        cyc[1] = 1'b0;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL abort_no_ack: got %0d acks expected 0", acks);
        end
        rd(1, 32'h40, 2'b10, 32'h55AA55AA);
    endtask

    task automatic test_back_to_back();
        int acks;
        drive_req(1, 1'b1, 32'h44, 32'h0BADCAFE, 2'b10);
        @(negedge clk);
        stb[1] = 1'b1; addr[1] = 32'h48; wdata[1] = 32'h99999999;
        @(posedge clk);
        #1 stb[1] = 1'b0;
        acks = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) begin
                acks++;
                stb[1] = 1'b1;
            end else begin
                stb[1] = 1'b0;
            end
        end
        cyc[1] = 1'b0;
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL busy_single_ack: got %0d acks expected 1", acks);
        end
        rd(1, 32'h44, 2'b10, 32'h0BADCAFE);
    endtask

    task automatic test_reset_mid();
        int lat;
        drive_req(1, 1'b1, 32'h44, 32'h77777777, 2'b10);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ack[1] !== 1'b0 || rdata[1] !== 32'h0 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_wait: got ack %b data %h/%h expected 0 0/0", ack[1], rdata[1], rdata[0]);
        end
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        cyc[1] = 1'b0;
        rd(1, 32'h44, 2'b10, 32'h0BADCAFE);
        drive_req(1, 1'b0, 32'h40, 32'h0, 2'b10);
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) lat = n;
        end
        checks++;
        if (lat != 4 || rdata[1] !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL pre_reset_ack: got lat %0d data %h expected 4 55aa55aa", lat, rdata[1]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ack[1] !== 1'b0 || rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_during_ack: got ack %b data %h expected 0 0", ack[1], rdata[1]);
        end
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        cyc[1] = 1'b0;
        rd(1, 32'h40, 2'b10, 32'h55AA55AA);
    endtask

`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
    task automatic err_xfer(input logic w_en, input logic [31:0] a, input logic [1:0] w);
        int lat;
        int acks;
        drive_req(0, w_en, a, 32'h0, w);
        lat = 0;
        acks = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (err[0] === 1'b1 && lat == 0) lat = n;
            if (ack[0] === 1'b1) acks++;
        end
        cyc[0] = 1'b0;
        checks++;
        if (lat != 2 || acks != 0) begin
            errors++;
            $display("FAIL align_err addr %h: got err lat %0d acks %0d expected 2 0", a, lat, acks);
        end
        checks++;
        if (rdata[0] !== last_rd[0]) begin
            errors++;
            $display("FAIL align_err_data addr %h: got %h expected %h", a, rdata[0], last_rd[0]);
        end
    endtask

    task automatic test_align_err();
        rd(0, 32'h30, 2'b10, 32'hABCDFFFF);
        err_xfer(1'b0, 32'h41, 2'b10);
        err_xfer(1'b1, 32'h31, 2'b01);
        rd(0, 32'h30, 2'b10, 32'hABCDFFFF);
    endtask
`endif

    initial begin
        for (int s = 0; s < 2; s++) begin
            cyc[s] = 1'b0; stb[s] = 1'b0; we[s] = 1'b0;
            addr[s] = '0; wdata[s] = '0; width[s] = 2'b10;
            last_rd[s] = '0;
        end
        test_reset();
        test_word();
        test_bytes();
        test_short();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_MEM_RESPONDER_ALIGN_ERR_EN
        test_align_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Wishbone slave memory that answers the CPU's instruction/data fetch master.
- Single-beat transfers only: read or write of a byte, short or word.
- One access outstanding at a time, with a configurable response latency.
- Sits on the SOC bus as the main RAM behind the CPU's fetch/load-store port.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words
WAIT_STATES, 1, extra cycles between request capture and ack (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
i_wb_cyc  input  1  bus cycle active
i_wb_stb  input  1  request strobe (master holds it for exactly one cycle)
i_wb_we  input  1  1 = write, 0 = read
i_wb_addr  input  32  byte address
i_wb_data  input  32  write data, right-aligned (byte in [7:0], short in [15:0])
i_data_width  input  2  00 = byte, 01 = short, 10 = word, 11 = treated as word
o_wb_data  output  32  read data, right-aligned and zero-extended
o_wb_ack  output  1  one-cycle transfer-complete pulse

Behaviour:
- Reset (async assert, sync release): state IDLE, o_wb_ack=0, o_wb_data=0, wait counter 0. Memory contents are not cleared.
- Addressing: word index = i_wb_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*depth.
- Byte lanes are little-endian:
  - byte: lane = addr[1:0]
  - short: lanes addr[1]*2 and addr[1]*2+1; addr[0] is ignored
  - word: addr[1:0] are ignored
- FSM:
  - IDLE: on i_wb_cyc && i_wb_stb, latch addr/we/data/width, load counter = WAIT_STATES, go to WAIT (or straight to ACK when WAIT_STATES=0).
  - WAIT: decrement the counter each cycle; when it reaches 1 (or is 0), go to ACK on the next edge.
  - ACK: o_wb_ack=1 for exactly one cycle, then return to IDLE.
- Latency: with stb sampled at edge N, ack is high during cycle N+1+WAIT_STATES.
- Write: the masked byte write commits on the edge that enters ACK. Unselected lanes are unchanged.
- Read: o_wb_data is registered on the edge entering ACK, selected lanes shifted down and zero-extended. o_wb_data holds its value until the next read completes; it is unchanged by writes.
- Abort: i_wb_cyc low in WAIT means go to IDLE, no write commits, no ack.
  - i_wb_cyc low during ACK has no effect (ack still pulses; the transfer is already committed).
- Busy: i_wb_stb outside IDLE (including the ACK cycle) is ignored, not queued. The next request is accepted from the cycle after ACK.
- i_wb_stb without i_wb_cyc is ignored.
- Reset mid-operation: immediate return to IDLE, ack drops asynchronously. A pending write is lost.

Optional Feature:
Macro WB_MEM_RESPONDER_ALIGN_ERR_EN.
- Defined:
  - Adds output o_wb_err (1 bit, reset 0).
  - Misaligned request (short with addr[0]=1, or word with addr[1:0]!=0) completes with o_wb_err=1 instead of ack, with the same timing.
  - No memory write occurs and o_wb_data is unchanged.
- Undefined: no o_wb_err port; misaligned low address bits are ignored as described in Behaviour.

Decomposition:
- Package wb_pkg:
  - width encodings WB_BYTE=2'b00, WB_SHORT=2'b01, WB_WORD=2'b10
  - FSM state encoding IDLE/WAIT/ACK
  - function returning the 4-bit byte-enable from (width, addr[1:0])
- Natural sub-module: wb_byte_lane, purely combinational. It maps (width, addr[1:0], right-aligned data) to (byte-enable, lane-positioned write data), and maps (read word, width, addr[1:0]) to right-aligned zero-extended data.
- Top level: FSM, counter, memory array.

Test Plan:
- WAIT_STATES=1: write word 0xDEADBEEF @0x10, then read @0x10 -> ack 2 cycles after each stb; o_wb_data=0xDEADBEEF.
- Byte writes 0x11, 0x22, 0x33, 0x44 to @0x20..0x23, then word read @0x20 -> 0x44332211. Byte read @0x22 -> 0x00000033.
- Short write 0xABCD @0x32 over word 0xFFFFFFFF @0x30 -> word read 0xABCDFFFF; short read @0x32 -> 0x0000ABCD.
- WAIT_STATES=3: drop i_wb_cyc 1 cycle after a write of 0x12345678 @0x40 -> no ack; a later read @0x40 returns the previous contents.
- Reset asserted mid-WAIT -> o_wb_ack and o_wb_data go 0 immediately. A read issued after release returns the pre-reset memory value.
- Wrap and busy: with ADDR_WIDTH=10, write @0x1000 then read @0x0000 -> same data. A second stb during WAIT -> exactly one ack.
- With WB_MEM_RESPONDER_ALIGN_ERR_EN: word read @0x41 -> o_wb_err pulse, no ack, o_wb_data unchanged.
